// File: rtl/pixel_queue_sc.sv
// Single-clock pixel output queue between the pixel generator and the video
// output stage. Stores CHANNELS x CHAN_WIDTH component fields plus a position
// tag per word. Supports standard registered read (FWFT=0) and
// first-word-fall-through (FWFT=1), synchronous flush, occupancy count and
// programmable almost-full/almost-empty flags.
// Ports:
//   clk, rst (async, active-high), clk_en (global enable), flush (sync clear)
//   write side : pix_in, position_in, wr_en -> full, almost_full, overflow
//   read side  : rd_en -> pix_out, position_out, valid, empty, almost_empty,
//                underflow
//   count      : occupancy, including the FWFT head register
module pixel_queue_sc #(
  parameter int unsigned ADDR_WIDTH        = 4,
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned CHAN_WIDTH        = 8,
  parameter int unsigned POS_WIDTH         = 3,
  parameter int unsigned PROG_FULL_THRESH  = 12,
  parameter int unsigned PROG_EMPTY_THRESH = 2,
  parameter int unsigned FWFT              = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic                           flush,
  input  logic [CHANNELS*CHAN_WIDTH-1:0] pix_in,
  input  logic [POS_WIDTH-1:0]           position_in,
  input  logic                           wr_en,
  output logic                           full,
  output logic                           almost_full,
  output logic                           overflow,
  output logic [CHANNELS*CHAN_WIDTH-1:0] pix_out,
  output logic [POS_WIDTH-1:0]           position_out,
  input  logic                           rd_en,
  output logic                           empty,
  output logic                           valid,
  output logic                           underflow,
  output logic                           almost_empty,
  output logic [ADDR_WIDTH:0]            count
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned PIX_W  = CHANNELS * CHAN_WIDTH;
  localparam int unsigned WORD_W = PIX_W + POS_WIDTH;
  localparam int unsigned CW     = ADDR_WIDTH + 1;
  localparam bit          IS_FWFT = (FWFT != 0);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]         mem_cnt, mem_cnt_n, count_q, count_n;
  logic [WORD_W-1:0]     rd_q, head_q;
  logic                  stage_vld, stage_vld_n, head_vld, head_vld_n;
  logic                  rd_vld, rd_vld_n;
  logic                  full_q, full_n, empty_q, empty_n;
  logic                  afull_q, afull_n, aempty_q, aempty_n;
  logic                  ovf_q, ovf_n, udf_q, udf_n;
  logic                  wr_acc, rd_acc, mem_rd, head_load;

  // Next-state: acceptance, RAM read scheduling, occupancy and flags
  always_comb begin
    wr_acc      = wr_en & clk_en & ~full_q & ~flush;
    rd_acc      = rd_en & clk_en & ~empty_q & ~flush;
    head_load   = 1'b0;
    mem_rd      = rd_acc;
    stage_vld_n = 1'b0;
    head_vld_n  = 1'b0;
    rd_vld_n    = 1'b0;
    if (IS_FWFT) begin
      // RAM read stage refills whenever it is empty or moving into the head
      head_load   = clk_en & ~flush & stage_vld & (~head_vld | rd_acc);
      mem_rd      = clk_en & ~flush & (mem_cnt != '0) & (~stage_vld | head_load);
      stage_vld_n = mem_rd | (stage_vld & ~head_load);
      head_vld_n  = head_load | (head_vld & ~rd_acc);
    end else begin
      rd_vld_n    = rd_acc;
    end
    wr_ptr_n  = wr_ptr + ADDR_WIDTH'(wr_acc);
    rd_ptr_n  = rd_ptr + ADDR_WIDTH'(mem_rd);
    mem_cnt_n = mem_cnt + CW'(wr_acc) - CW'(mem_rd);
    if (flush) begin
      wr_ptr_n    = '0;
      rd_ptr_n    = '0;
      mem_cnt_n   = '0;
      stage_vld_n = 1'b0;
      head_vld_n  = 1'b0;
      rd_vld_n    = 1'b0;
    end
    count_n  = IS_FWFT ? (mem_cnt_n + CW'(stage_vld_n) + CW'(head_vld_n)) : mem_cnt_n;
    full_n   = (count_n == CW'(DEPTH));
    afull_n  = (count_n >= CW'(PROG_FULL_THRESH));
    aempty_n = (count_n <= CW'(PROG_EMPTY_THRESH));
    empty_n  = IS_FWFT ? ~head_vld_n : (count_n == '0);
    ovf_n    = wr_en & full_q & ~flush;
    udf_n    = rd_en & empty_q & ~flush;
  end

  // State registers; nothing moves unless clk_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      count_q   <= '0;
      stage_vld <= 1'b0;
      head_vld  <= 1'b0;
      rd_vld    <= 1'b0;
      rd_q      <= '0;
      head_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else if (clk_en) begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      mem_cnt   <= mem_cnt_n;
      count_q   <= count_n;
      stage_vld <= stage_vld_n;
      head_vld  <= head_vld_n;
      rd_vld    <= rd_vld_n;
      if (mem_rd)    rd_q   <= mem[rd_ptr];
      if (head_load) head_q <= rd_q;
      full_q    <= full_n;
      empty_q   <= empty_n;
      afull_q   <= afull_n;
      aempty_q  <= aempty_n;
      ovf_q     <= ovf_n;
      udf_q     <= udf_n;
    end
  end

  // Storage array write port (no reset so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {pix_in, position_in};
  end

  assign pix_out      = IS_FWFT ? head_q[WORD_W-1:POS_WIDTH] : rd_q[WORD_W-1:POS_WIDTH];
  assign position_out = IS_FWFT ? head_q[POS_WIDTH-1:0] : rd_q[POS_WIDTH-1:0];
  assign valid        = IS_FWFT ? head_vld : rd_vld;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign underflow    = udf_q;
  assign count        = count_q;

endmodule

// File: tb/tb_pixel_queue_sc.sv
module tb_pixel_queue_sc;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush;
  logic [31:0] pix_in;
  logic [2:0]  position_in;
  logic        wr_en, rd_en, wr_en_b, rd_en_b;

  logic        full, almost_full, overflow, empty, valid, underflow, almost_empty;
  logic [31:0] pix_out;
  logic [2:0]  position_out;
  logic [4:0]  count;

  logic        full_b, almost_full_b, overflow_b, empty_b, valid_b, underflow_b, almost_empty_b;
  logic [31:0] pix_out_b;
  logic [2:0]  position_out_b;
  logic [4:0]  count_b;

  int total = 0;
  int bad   = 0;
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic [34:0] last_word;

  always #5 clk = ~clk;

  pixel_queue_sc #(.FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .pix_in(pix_in), .position_in(position_in), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .overflow(overflow),
    .pix_out(pix_out), .position_out(position_out), .rd_en(rd_en),
    .empty(empty), .valid(valid), .underflow(underflow),
    .almost_empty(almost_empty), .count(count)
  );

  pixel_queue_sc #(.FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .pix_in(pix_in), .position_in(position_in), .wr_en(wr_en_b),
    .full(full_b), .almost_full(almost_full_b), .overflow(overflow_b),
    .pix_out(pix_out_b), .position_out(position_out_b), .rd_en(rd_en_b),
    .empty(empty_b), .valid(valid_b), .underflow(underflow_b),
    .almost_empty(almost_empty_b), .count(count_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int i);
    pix_in      = 32'hA0B0C0D0 + 32'(i);
    position_in = 3'(i);
  endtask

  function automatic logic [34:0] word_of(input int i);
    logic [31:0] p;
    p = 32'hA0B0C0D0 + 32'(i);
    return {p, 3'(i)};
  endfunction

  // Standard-mode monitor: each valid cycle is one read word
  always @(negedge clk) begin
    if (!rst && valid) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL mon0_unexpected: got %0h expected none", {pix_out, position_out});
      end else begin
        logic [34:0] e;
        e = q0.pop_front();
        if ({pix_out, position_out} !== e) begin
          bad++;
          $display("FAIL mon0_data: got %0h expected %0h", {pix_out, position_out}, e);
        end
      end
    end
  end

  // FWFT monitor: a word is consumed when rd_en meets valid
  always @(negedge clk) begin
    if (!rst && clk_en && rd_en_b && valid_b) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL mon1_unexpected: got %0h expected none", {pix_out_b, position_out_b});
      end else begin
        logic [34:0] e;
        e = q1.pop_front();
        if ({pix_out_b, position_out_b} !== e) begin
          bad++;
          $display("FAIL mon1_data: got %0h expected %0h", {pix_out_b, position_out_b}, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
    drive_word(0);
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_aempty", 64'(almost_empty), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_pix", 64'(pix_out), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    rst = 1'b0;
    tick();

    // Reset mid-fill at count 5
    for (int i = 0; i < 5; i++) begin
      drive_word(i); wr_en = 1'b1; q0.push_back(word_of(i)); tick();
    end
    wr_en = 1'b0;
    chk("midfill_count", 64'(count), 64'd5);
    rst = 1'b1;
    #2;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_aempty", 64'(almost_empty), 64'd1);
    chk("async_rst_valid", 64'(valid), 64'd0);
    chk("async_rst_pix", 64'(pix_out), 64'd0);
    chk("async_rst_pulses", 64'({overflow, underflow}), 64'd0);
    q0.delete();
    #1 rst = 1'b0;
    tick();

    // Fill to full, check threshold flags
    for (int i = 0; i < 16; i++) begin
      drive_word(i); wr_en = 1'b1; q0.push_back(word_of(i)); tick();
      if (i == 10) chk("afull_at11", 64'(almost_full), 64'd0);
      if (i == 11) chk("afull_at12", 64'(almost_full), 64'd1);
      if (i == 14) chk("full_at15", 64'(full), 64'd0);
    end
    chk("full_at16", 64'(full), 64'd1);
    chk("count16", 64'(count), 64'd16);
    drive_word(99); tick();
    wr_en = 1'b0;
    chk("overflow_pulse", 64'(overflow), 64'd1);
    chk("overflow_count", 64'(count), 64'd16);
    tick();
    chk("overflow_clear", 64'(overflow), 64'd0);

    // Drain in order
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    rd_en = 1'b0;
    chk("drain_underflow", 64'(underflow), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_count", 64'(count), 64'd0);
    tick();

    // Simultaneous read/write at count 8 across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive_word(100 + i); wr_en = 1'b1; q0.push_back(word_of(100 + i)); tick();
    end
    chk("sim_start_count", 64'(count), 64'd8);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_word(200 + i); q0.push_back(word_of(200 + i)); last_word = word_of(200 + i);
      tick();
      chk("sim_count", 64'(count), 64'd8);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rd_en = 1'b0;
    chk("sim_drain_count", 64'(count), 64'd0);
    tick();
    chk("idle_valid", 64'(valid), 64'd0);

    // Read from empty queue
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("uf_pulse", 64'(underflow), 64'd1);
    chk("uf_valid", 64'(valid), 64'd0);
    chk("uf_pix_hold", 64'({pix_out, position_out}), 64'(last_word));
    tick();
    chk("uf_clear", 64'(underflow), 64'd0);

    // Flush with a concurrent write
    for (int i = 0; i < 6; i++) begin
      drive_word(300 + i); wr_en = 1'b1; tick();
    end
    chk("pre_flush_count", 64'(count), 64'd6);
    flush = 1'b1; drive_word(306); tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_overflow", 64'(overflow), 64'd0);
    tick();
    chk("flush_write_dropped", 64'(count), 64'd0);

    // clk_en low freezes everything
    for (int i = 0; i < 3; i++) begin
      drive_word(400 + i); wr_en = 1'b1; q0.push_back(word_of(400 + i)); tick();
    end
    wr_en = 1'b0; tick();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = i[0]; rd_en = ~i[0]; tick();
      chk("ce_count", 64'(count), 64'd3);
      chk("ce_flags", 64'({valid, empty, overflow, underflow}), 64'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0; clk_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rd_en = 1'b0;
    tick();

    // FWFT latency: write at edge N
    drive_word(500); wr_en_b = 1'b1; q1.push_back(word_of(500)); tick();
    wr_en_b = 1'b0;
    chk("fwft_count_n", 64'(count_b), 64'd1);
    chk("fwft_valid_n", 64'(valid_b), 64'd0);
    tick();
    chk("fwft_valid_n1", 64'(valid_b), 64'd0);
    tick();
    chk("fwft_valid_n2", 64'(valid_b), 64'd1);
    chk("fwft_data_n2", 64'({pix_out_b, position_out_b}), 64'(word_of(500)));
    rd_en_b = 1'b1; tick(); rd_en_b = 1'b0;
    chk("fwft_pop_valid", 64'(valid_b), 64'd0);
    chk("fwft_pop_empty", 64'(empty_b), 64'd1);
    chk("fwft_pop_count", 64'(count_b), 64'd0);

    // FWFT back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive_word(600 + i); wr_en_b = 1'b1; q1.push_back(word_of(600 + i)); tick();
    end
    wr_en_b = 1'b0;
    tick(); tick();
    chk("fwft_b2b_count", 64'(count_b), 64'd4);
    rd_en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fwft_b2b_valid", 64'(valid_b), (i < 3) ? 64'd1 : 64'd0);
    end
    rd_en_b = 1'b0;
    chk("fwft_b2b_count_end", 64'(count_b), 64'd0);
    tick();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
